// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg
// Shared definitions for the receive-chain symbol buffer: FSM state encoding,
// symbol-counter width and the default RAM geometry used by both the buffer
// controller and the ASPRAM instance in the parent.
package rx_buf_pkg;

    // Default RAM geometry, shared with the ASPRAM instance
    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned RAM_DEPTH_DEF  = 32;

    // Completed-block counter width
    localparam int unsigned SYM_CNT_W = 8;

    // Controller FSM encoding
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/rx_sym_buf_ctrl.sv
// rx_sym_buf_ctrl
// Write-then-read sequencer for a single-port asynchronous-read RAM. A block of
// BLOCK_LEN words is accepted from the upstream stream into addresses
// 0..BLOCK_LEN-1, then drained in address order to the downstream stream.
// Fill and drain alternate so the single RAM port is never contended.
//
// Ports:
//   iClk, iRst        clock (rising edge), asynchronous active-high reset
//   iFlush            synchronous abort, discards the current block
//   iIn_*/oIn_Ready   upstream valid/ready stream
//   oOut_*/iOut_Ready downstream valid/ready stream, oOut_Last on final word
//   oSym_Cnt          completed-block count, wraps
//   oRam_*/iRam_Data  RAM port (write/read enables, address, write data,
//                     asynchronous read data)
module rx_sym_buf_ctrl
    import rx_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int unsigned BLOCK_LEN  = RAM_DEPTH_DEF
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFlush,
    input  logic                  iIn_Valid,
    output logic                  oIn_Ready,
    input  logic [DATA_WIDTH-1:0] iIn_Data,
    output logic                  oOut_Valid,
    input  logic                  iOut_Ready,
    output logic [DATA_WIDTH-1:0] oOut_Data,
    output logic                  oOut_Last,
    output logic [SYM_CNT_W-1:0]  oSym_Cnt,
    output logic                  oRam_W_EN,
    output logic                  oRam_R_EN,
    output logic [ADDR_WIDTH-1:0] oRam_Addr,
    output logic [DATA_WIDTH-1:0] oRam_Data,
    input  logic [DATA_WIDTH-1:0] iRam_Data
);

    // Elaboration-time sanity check on the block geometry
    if (BLOCK_LEN < 1 || BLOCK_LEN > RAM_DEPTH || RAM_DEPTH > (2 ** ADDR_WIDTH)) begin : gBadGeom
        $error("rx_sym_buf_ctrl: illegal BLOCK_LEN/RAM_DEPTH/ADDR_WIDTH combination");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLOCK_LEN - 1);

    logic [0:0]           stateQ, stateD;
    logic [ADDR_WIDTH-1:0] addrQ, addrD;
    logic [SYM_CNT_W-1:0] symCntQ, symCntD;

    logic isFill;
    logic atLast;

    assign isFill = (stateQ == ST_FILL);
    assign atLast = (addrQ == LAST_ADDR);

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        symCntD = symCntQ;
        if (iFlush) begin
            // Abort overrides any handshake in the same cycle
            stateD = ST_FILL;
            addrD  = '0;
        end else if (isFill) begin
            if (iIn_Valid) begin
                if (atLast) begin
                    addrD  = '0;
                    stateD = ST_DRAIN;
                end else begin
                    addrD = addrQ + ADDR_WIDTH'(1);
                end
            end
        end else begin
            if (iOut_Ready) begin
                if (atLast) begin
                    addrD   = '0;
                    stateD  = ST_FILL;
                    symCntD = symCntQ + SYM_CNT_W'(1);
                end else begin
                    addrD = addrQ + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ  <= ST_FILL;
            addrQ   <= '0;
            symCntQ <= '0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            symCntQ <= symCntD;
        end
    end

    assign oIn_Ready  = isFill;
    assign oOut_Valid = ~isFill;
    // Read data passes straight through the RAM's asynchronous read port
    assign oOut_Data  = isFill ? '0 : iRam_Data;
    assign oOut_Last  = ~isFill & atLast;
    assign oSym_Cnt   = symCntQ;
    assign oRam_W_EN  = isFill & iIn_Valid & ~iFlush;
    assign oRam_R_EN  = ~isFill;
    assign oRam_Addr  = addrQ;
    assign oRam_Data  = iIn_Data;

endmodule

// File: tb/tb_rx_sym_buf_ctrl.sv
module tb_rx_sym_buf_ctrl;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    // Main DUT, BLOCK_LEN = 32
    logic        iFlush = 1'b0, iIn_Valid = 1'b0, iOut_Ready = 1'b1;
    logic [63:0] iIn_Data = '0;
    logic        oIn_Ready, oOut_Valid, oOut_Last, oRam_W_EN, oRam_R_EN;
    logic [63:0] oOut_Data, oRam_Data, iRam_Data;
    logic [7:0]  oSym_Cnt;
    logic [4:0]  oRam_Addr;

    // Second DUT, BLOCK_LEN = 1
    logic        iFlush1 = 1'b0, iIn_Valid1 = 1'b0, iOut_Ready1 = 1'b1;
    logic [63:0] iIn_Data1 = '0;
    logic        oIn_Ready1, oOut_Valid1, oOut_Last1, oRam_W_EN1, oRam_R_EN1;
    logic [63:0] oOut_Data1, oRam_Data1, iRam_Data1;
    logic [7:0]  oSym_Cnt1;
    logic [4:0]  oRam_Addr1;

    rx_sym_buf_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .RAM_DEPTH(32), .BLOCK_LEN(32)) dut (
        .iClk(iClk), .iRst(iRst), .iFlush(iFlush),
        .iIn_Valid(iIn_Valid), .oIn_Ready(oIn_Ready), .iIn_Data(iIn_Data),
        .oOut_Valid(oOut_Valid), .iOut_Ready(iOut_Ready), .oOut_Data(oOut_Data),
        .oOut_Last(oOut_Last), .oSym_Cnt(oSym_Cnt),
        .oRam_W_EN(oRam_W_EN), .oRam_R_EN(oRam_R_EN), .oRam_Addr(oRam_Addr),
        .oRam_Data(oRam_Data), .iRam_Data(iRam_Data)
    );

    rx_sym_buf_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .RAM_DEPTH(32), .BLOCK_LEN(1)) dut1 (
        .iClk(iClk), .iRst(iRst), .iFlush(iFlush1),
        .iIn_Valid(iIn_Valid1), .oIn_Ready(oIn_Ready1), .iIn_Data(iIn_Data1),
        .oOut_Valid(oOut_Valid1), .iOut_Ready(iOut_Ready1), .oOut_Data(oOut_Data1),
        .oOut_Last(oOut_Last1), .oSym_Cnt(oSym_Cnt1),
        .oRam_W_EN(oRam_W_EN1), .oRam_R_EN(oRam_R_EN1), .oRam_Addr(oRam_Addr1),
        .oRam_Data(oRam_Data1), .iRam_Data(iRam_Data1)
    );

    // Behavioural ASPRAMs with their own reset
    logic [63:0] mem  [32];
    logic [63:0] mem1 [32];
    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  <= '0;
                mem1[i] <= '0;
            end
        end else begin
            if (oRam_W_EN)  mem[oRam_Addr]   <= oRam_Data;
            if (oRam_W_EN1) mem1[oRam_Addr1] <= oRam_Data1;
        end
    end
    assign iRam_Data  = oRam_R_EN  ? mem[oRam_Addr]   : '0;
    assign iRam_Data1 = oRam_R_EN1 ? mem1[oRam_Addr1] : '0;

    // Scoreboards: {last, data} pushed on input handshake, popped on output handshake
    logic [64:0] expQ[$];
    logic [64:0] exp1Q[$];
    logic [4:0]  wrIdx   = '0;
    logic [7:0]  symExp  = '0;
    logic [7:0]  sym1Exp = '0;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge drive: samples, updates models, advances one cycle
    task automatic tick();
        logic [64:0] e;
        #1;
        chk("sym_cnt", {56'd0, oSym_Cnt}, {56'd0, symExp});
        chk("no_write_while_out_valid", {63'd0, oRam_W_EN & oOut_Valid}, 64'd0);
        if (iFlush) begin
            chk("flush_no_write", {63'd0, oRam_W_EN}, 64'd0);
            expQ.delete();
            wrIdx = '0;
        end else begin
            if (iIn_Valid && oIn_Ready) begin
                chk("wr_en", {63'd0, oRam_W_EN}, 64'd1);
                chk("wr_addr", {59'd0, oRam_Addr}, {59'd0, wrIdx});
                expQ.push_back({wrIdx == 5'd31, iIn_Data});
                wrIdx = (wrIdx == 5'd31) ? 5'd0 : wrIdx + 5'd1;
            end
            if (oOut_Valid) begin
                if (expQ.size() == 0) begin
                    chk("out_without_input", {63'd0, oOut_Valid}, 64'd0);
                end else begin
                    e = expQ[0];
                    chk("out_data", oOut_Data, e[63:0]);
                    chk("out_last", {63'd0, oOut_Last}, {63'd0, e[64]});
                    if (iOut_Ready) begin
                        void'(expQ.pop_front());
                        if (e[64]) symExp++;
                    end
                end
            end
        end
        // BLOCK_LEN = 1 instance
        chk("sym_cnt1", {56'd0, oSym_Cnt1}, {56'd0, sym1Exp});
        if (iIn_Valid1 && oIn_Ready1) exp1Q.push_back({1'b1, iIn_Data1});
        if (oOut_Valid1) begin
            if (exp1Q.size() == 0) begin
                chk("out1_without_input", {63'd0, oOut_Valid1}, 64'd0);
            end else begin
                e = exp1Q[0];
                chk("out1_data", oOut_Data1, e[63:0]);
                chk("out1_last", {63'd0, oOut_Last1}, 64'd1);
                if (iOut_Ready1) begin
                    void'(exp1Q.pop_front());
                    sym1Exp++;
                end
            end
        end
        @(negedge iClk);
    endtask

    task automatic fillBlock(input logic [63:0] base);
        iOut_Ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            iIn_Valid = 1'b1;
            iIn_Data  = base + 64'(i);
            tick();
        end
        iIn_Valid = 1'b0;
    endtask

    task automatic drainN(input int n);
        iIn_Valid  = 1'b0;
        iOut_Ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", {63'd0, oOut_Valid}, 64'd1);
            tick();
        end
    endtask

    task automatic chkIdle(input string tag, input logic [7:0] cnt);
        chk({tag, "_in_ready"},  {63'd0, oIn_Ready},  64'd1);
        chk({tag, "_out_valid"}, {63'd0, oOut_Valid}, 64'd0);
        chk({tag, "_out_last"},  {63'd0, oOut_Last},  64'd0);
        chk({tag, "_r_en"},      {63'd0, oRam_R_EN},  64'd0);
        chk({tag, "_addr"},      {59'd0, oRam_Addr},  64'd0);
        chk({tag, "_out_data"},  oOut_Data,           64'd0);
        chk({tag, "_sym_cnt"},   {56'd0, oSym_Cnt},   {56'd0, cnt});
    endtask

    initial begin
        logic [7:0] startCnt;
        int n;

        // Reset state
        #2;
        chkIdle("reset", 8'd0);
        chk("reset_w_en", {63'd0, oRam_W_EN}, 64'd0);
        @(negedge iClk);
        iRst = 1'b0;

        // Scenario 1: words 0x1..0x20, continuous valid/ready
        fillBlock(64'h1);
        chk("s1_first_out_valid", {63'd0, oOut_Valid}, 64'd1);
        chk("s1_first_out_data", oOut_Data, 64'h1);
        drainN(32);
        chkIdle("s1_done", 8'd1);

        // Scenario 2: random gaps and stalls over 3 blocks
        startCnt = symExp;
        n = 0;
        while (symExp != startCnt + 8'd3 && n < 3000) begin
            iIn_Valid  = ($urandom_range(0, 3) != 0);
            iIn_Data   = {$urandom, $urandom};
            iOut_Ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        iIn_Valid  = 1'b0;
        iOut_Ready = 1'b1;
        chk("s2_sym_cnt", {56'd0, oSym_Cnt}, {56'd0, startCnt + 8'd3});

        // Scenario 3: flush after 10 fill words, then a fresh block
        startCnt = oSym_Cnt;
        for (int i = 0; i < 10; i++) begin
            iIn_Valid = 1'b1;
            iIn_Data  = 64'hA000 + 64'(i);
            tick();
        end
        iFlush   = 1'b1;
        iIn_Data = 64'hDEAD;
        tick();
        iFlush = 1'b0;
        chkIdle("s3_after_flush", startCnt);
        fillBlock(64'hB000);
        drainN(32);
        chk("s3_sym_cnt", {56'd0, oSym_Cnt}, {56'd0, startCnt + 8'd1});

        // Scenario 4: flush mid-drain at address 7
        startCnt = oSym_Cnt;
        fillBlock(64'hC000);
        drainN(7);
        chk("s4_addr7", {59'd0, oRam_Addr}, 64'd7);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        chkIdle("s4_after_flush", startCnt);
        fillBlock(64'hD000);
        drainN(32);
        chk("s4_sym_cnt", {56'd0, oSym_Cnt}, {56'd0, startCnt + 8'd1});

        // Scenario 5: asynchronous reset mid-drain
        fillBlock(64'hE000);
        drainN(5);
        #2;
        iRst = 1'b1;
        #1;
        chkIdle("s5_async_reset", 8'd0);
        expQ.delete();
        wrIdx  = '0;
        symExp = '0;
        @(negedge iClk);
        iRst = 1'b0;
        fillBlock(64'h1);
        chk("s5_first_out_data", oOut_Data, 64'h1);
        drainN(32);
        chkIdle("s5_done", 8'd1);

        // Scenario 6: BLOCK_LEN = 1, 257 blocks, counter wrap
        iOut_Ready1 = 1'b1;
        for (int k = 0; k < 257; k++) begin
            chk("b1_fill_ready", {63'd0, oIn_Ready1}, 64'd1);
            chk("b1_fill_no_valid", {63'd0, oOut_Valid1}, 64'd0);
            iIn_Valid1 = 1'b1;
            iIn_Data1  = 64'h5000 + 64'(k);
            tick();
            chk("b1_drain_valid", {63'd0, oOut_Valid1}, 64'd1);
            chk("b1_drain_last", {63'd0, oOut_Last1}, 64'd1);
            chk("b1_drain_not_ready", {63'd0, oIn_Ready1}, 64'd0);
            iIn_Data1 = 64'hFFFF;
            tick();
            if (k == 255) chk("b1_wrap_to_0", {56'd0, oSym_Cnt1}, 64'd0);
        end
        iIn_Valid1 = 1'b0;
        chk("b1_wrap_to_1", {56'd0, oSym_Cnt1}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
